// File: rtl/line_mem_if.sv
// Cache-line request/response bus between a line requester (master) and line_mem_responder
// (slave).
interface line_mem_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [31:0]  req_addr;
  logic [255:0] req_line;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_line;

  modport master (
    output req_valid, req_we, req_addr, req_line, rsp_ready,
    input  req_ready, rsp_valid, rsp_line
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_line, rsp_ready,
    output req_ready, rsp_valid, rsp_line
  );
endinterface

// File: rtl/line_mem_responder.sv
// Line-granular memory responder: 8 x 32-bit beats per 256-bit line after a fixed wait.
// Define MEM_PERF_CNT_EN to build the read/write response counters; otherwise they read 0.
module line_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  line_mem_if.slave   bus,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
);
  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StXfer, StResp} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;  // wait countdown, then beat 0..7 plus one read-drain step
  logic               we_q, we_d;
  logic [AddrW-4:0]   line_q, line_d;
  logic [255:0]       wdata_q, wdata_d;
  logic [255:0]       rsp_line_q, rsp_line_d;
  logic [31:0]        rdata_q;
  logic [31:0]        mem_q [DEPTH_WORDS] = '{default: '0};
  logic [AddrW-1:0]   mem_addr;
  logic               mem_we;
  logic [2:0]         prev_beat;
  logic               accept;
  logic               rsp_done;
  logic               unused_addr;

  assign accept        = bus.req_valid & bus.req_ready;
  assign rsp_done      = (state_q == StResp) & bus.rsp_ready;
  assign bus.req_ready = (state_q == StIdle) & rst_ni;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_line  = rsp_line_q;
  assign mem_addr      = {line_q, cnt_q[2:0]};
  assign mem_we        = (state_q == StXfer) & we_q & ~cnt_q[3];
  assign prev_beat     = cnt_q[2:0] - 3'd1;
  assign unused_addr   = ^{bus.req_addr[31:AddrW+2], bus.req_addr[4:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    line_d     = line_q;
    wdata_d    = wdata_q;
    rsp_line_d = rsp_line_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d       = bus.req_we;
          line_d     = bus.req_addr[AddrW+1:5];
          wdata_d    = bus.req_line;
          rsp_line_d = '0;
          if (LATENCY == 0) begin
            state_d = StXfer;
            cnt_d   = '0;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StXfer;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StXfer: begin
        // Synchronous read data of beat k-1 is available while beat k is addressed.
        if (!we_q && cnt_q != '0) begin
          rsp_line_d[{prev_beat, 5'd0} +: 32] = rdata_q;
        end
        if (cnt_q == 4'd8) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      line_q     <= '0;
      wdata_q    <= '0;
      rsp_line_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      line_q     <= line_d;
      wdata_q    <= wdata_d;
      rsp_line_q <= rsp_line_d;
    end
  end

  // Memory is deliberately outside reset: an interrupted writeback keeps the beats it stored.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_addr] <= wdata_q[{cnt_q[2:0], 5'd0} +: 32];
    end
    rdata_q <= mem_q[mem_addr];
  end

`ifdef MEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (rsp_done) begin
      if (we_q) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end else begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif
endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: directed scenarios plus random line traffic
// compared against a word-array model of main memory.
module tb_line_mem_responder;
  localparam int unsigned DEPTH   = 4096;
  localparam int unsigned LATENCY = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  int          n_chk;
  int          n_fail;
  int          rd_exp;
  int          wr_exp;
  logic [31:0] mdl [DEPTH];

  line_mem_if bus ();

  line_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LATENCY)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .bus      (bus.slave),
    .rd_cnt_o (rd_cnt),
    .wr_cnt_o (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned line_base(input logic [31:0] addr);
    return ((addr / 4) % DEPTH) / 8 * 8;
  endfunction

  function automatic logic [255:0] mdl_line(input logic [31:0] addr);
    logic [255:0] l;
    int unsigned  b;
    b = line_base(addr);
    for (int k = 0; k < 8; k++) l[32*k +: 32] = mdl[b + k];
    return l;
  endfunction

  task automatic chk_cnt(input string tag);
`ifdef MEM_PERF_CNT_EN
    check({tag, " rd_cnt"}, 256'(rd_cnt), 256'(rd_exp));
    check({tag, " wr_cnt"}, 256'(wr_cnt), 256'(wr_exp));
`else
    check({tag, " rd_cnt"}, 256'(rd_cnt), 256'(0));
    check({tag, " wr_cnt"}, 256'(wr_cnt), 256'(0));
`endif
  endtask

  // One complete request/response; rsp_ready is withheld for 'hold' cycles of the response.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [255:0] wline,
                     input int hold, input string tag);
    int           lat;
    int           guard;
    logic         busy_ready;
    logic [255:0] exp;
    exp           = we ? 256'(0) : mdl_line(addr);
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_line  = wline;
    bus.req_valid = 1'b1;
    bus.rsp_ready = (hold == 0);
    guard = 0;
    while (!bus.req_ready && guard < 32) begin
      tick();
      guard++;
    end
    check({tag, " req_ready idle"}, 256'(bus.req_ready), 256'(1));
    tick();
    // Held request with changed contents must be ignored while busy.
    bus.req_we   = ~we;
    bus.req_addr = $urandom;
    bus.req_line = {8{$urandom}};
    lat = 0;
    busy_ready = 1'b0;
    while (!bus.rsp_valid && lat < 40) begin
      busy_ready |= bus.req_ready;
      tick();
      lat++;
    end
    bus.req_valid = 1'b0;
    check({tag, " latency"}, 256'(lat), 256'(LATENCY + 9));
    check({tag, " req_ready busy"}, 256'(busy_ready | bus.req_ready), 256'(0));
    check({tag, " rsp_line"}, bus.rsp_line, exp);
    for (int i = 1; i < hold; i++) begin
      tick();
      check({tag, " hold valid"}, 256'(bus.rsp_valid), 256'(1));
      check({tag, " hold line"}, bus.rsp_line, exp);
      check({tag, " hold req_ready"}, 256'(bus.req_ready), 256'(0));
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, " rsp_valid after"}, 256'(bus.rsp_valid), 256'(0));
    check({tag, " req_ready after"}, 256'(bus.req_ready), 256'(1));
    if (we) begin
      for (int k = 0; k < 8; k++) mdl[line_base(addr) + k] = wline[32*k +: 32];
      wr_exp++;
    end else begin
      rd_exp++;
    end
  endtask

  initial begin
    logic [255:0] l;
    logic [31:0]  a;
    n_chk  = 0;
    n_fail = 0;
    rd_exp = 0;
    wr_exp = 0;
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_line  = '1;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset with a request pending.
    tick();
    tick();
    check("reset req_ready", 256'(bus.req_ready), 256'(0));
    check("reset rsp_valid", 256'(bus.rsp_valid), 256'(0));
    check("reset rsp_line", bus.rsp_line, '0);
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    tick();
    check("post-reset req_ready", 256'(bus.req_ready), 256'(1));
    tick();
    check("post-reset no capture", 256'(bus.req_ready), 256'(1));
    chk_cnt("reset");

    // Write then read line 0x40.
    for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'(k) * 32'h1111_1111;
    txn(1'b1, 32'h40, l, 0, "wr40");
    txn(1'b0, 32'h40, '0, 0, "rd40");
    check("rd40 pattern word7", 256'(mdl_line(32'h40)), 256'(l));
    chk_cnt("after wr/rd");

    // Response held off for 5 cycles.
    txn(1'b0, 32'h40, '0, 5, "rd40 hold");

    // Offset bits and address alias.
    txn(1'b0, 32'h5C, '0, 0, "rd5c");
    txn(1'b0, DEPTH * 4 + 32'h40, '0, 1, "rd alias");

    // Writeback of 0x80 cut by reset during beat 3.
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h80;
    bus.req_line  = '1;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    repeat (LATENCY + 3) tick();
    rst_n = 1'b0;
    tick();
    check("midreset req_ready", 256'(bus.req_ready), 256'(0));
    check("midreset rsp_valid", 256'(bus.rsp_valid), 256'(0));
    rst_n = 1'b1;
    #1;
    check("midreset idle", 256'(bus.req_ready), 256'(1));
    for (int k = 0; k < 4; k++) mdl[line_base(32'h80) + k] = 32'hFFFF_FFFF;
    rd_exp = 0;
    wr_exp = 0;
    chk_cnt("midreset");
    txn(1'b0, 32'h80, '0, 0, "rd80 partial");

    // Random traffic over 16 lines with random offsets and alias bits.
    for (int i = 0; i < 24; i++) begin
      a = (32'($urandom_range(0, 15)) << 5) | ($urandom & 32'h1F)
          | (32'($urandom_range(0, 3)) * DEPTH * 4);
      l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      txn(1'($urandom_range(0, 1)), a, l, $urandom_range(0, 3), "rand");
    end
    chk_cnt("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
